pluse_sync_sched: RTL and testbench
===================================

# pluse_sync_sched

Source-domain scheduler that shares one `pluse_sync` instance between `N_REQ` single-cycle pulse requesters. It queues each requester's pulses and grants them round-robin. It issues at most one pulse every `GAP` `src_clk` cycles, so the slower destination clock never sees merged pulses. A requester ID is held stable alongside each pulse, so the destination can sample it on `des_pluse`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `GAP`, default 16: minimum `src_clk` cycles between issued pulses, ≥2; set ≥ 4×(des/src period ratio).
- `CNT_W`, default 4: pending-counter width, used only with `PLUSE_SCHED_CNT_EN`.
- `src_clk`  in  1  clock; all logic on rising edge.
- `src_rst_n`  in  1  reset, synchronous, active-low.
- `req_pluse`  in  `N_REQ`  per-requester pulse requests; each high cycle is one request.
- `ovf_clr`  in  1  clears all `ovf` bits.
- `s_pluse`  out  1  pulse to `pluse_sync.s_pluse`, exactly one cycle wide.
- `s_id`  out  `ID_W`=max(1,clog2(`N_REQ`))  requester of the latest issued pulse; held until the next issue.
- `busy`  out  1  high when state ≠ IDLE.
- `pend`  out  `N_REQ`  bit i high when requester i has ≥1 queued pulse.
- `ovf`  out  `N_REQ`  sticky; a request for i was dropped.

## Operation
- FSM states:
  - IDLE: when any `pend` bit is high → ISSUE. The arbiter winner is registered into `s_id`, and that requester's pending entry is decremented on the same edge.
  - ISSUE: `s_pluse`=1 for exactly this cycle. Go to GAP with counter loaded to `GAP`-3, or go directly to IDLE when `GAP`=2.
  - GAP: count down; at 0 → IDLE.
- Round-robin arbitration:
  - The search starts at last-granted+1 and wraps modulo `N_REQ`.
  - The last-grant pointer resets to `N_REQ`-1, so requester 0 wins first.
  - The pointer updates only on grant.
- Pending bookkeeping, per requester, each edge:
  - +1 if `req_pluse[i]`; −1 if granted.
  - Both on the same edge: net unchanged.
- Overflow:
  - A request arriving when the entry is already full and not granted that edge is dropped, and `ovf[i]` is set.
  - If `ovf_clr` and a new overflow occur on the same edge, set wins.
- Outputs are registered and derived from state and registers only; there is no combinational path from inputs to `s_pluse` or `s_id`.
- Reset values: state=IDLE, `s_pluse`=0, `s_id`=0, `busy`=0, `pend`=0, `ovf`=0, all counters 0, pointer=`N_REQ`-1.
- Reset asserted mid-operation aborts everything on that edge: an in-flight ISSUE/GAP is cut, and queued pulses are discarded.

## Timing
- Request to pulse: `req_pluse[i]` high in cycle c, with the block idle and no other pending → `pend[i]`=1 in c+1 → `s_pluse`=1 in c+2.
- Under continuous demand, successive `s_pluse` cycles are exactly `GAP` cycles apart: 1 ISSUE + (`GAP`-2) GAP + 1 IDLE.
- `s_id` changes only on the edge entering ISSUE. It is stable from the cycle `s_pluse` is high through at least `GAP`-1 following cycles.
- Requests are accepted every cycle, including during ISSUE and GAP.

## Configuration
- `PLUSE_SCHED_CNT_EN` defined:
  - Each requester has a `CNT_W`-bit saturating pending counter (max 2^`CNT_W`-1 queued pulses).
  - `pend[i]` = (count≠0); overflow occurs when the count is at max.
- `PLUSE_SCHED_CNT_EN` undefined:
  - Each requester has a single pending bit, and `CNT_W` is ignored.
  - A request while the bit is set and not granted that edge overflows.
  - Request plus grant on the same edge leaves the bit set.

## Structure
- Package `pluse_sync_pkg` holds:
  - the state enum (IDLE, ISSUE, GAP);
  - an `id_w(n)` function returning max(1,clog2(n));
  - the `GAP` minimum constant (2).
- One sub-module, `pluse_rr_arb`: combinational round-robin arbiter.
  - Inputs: request vector and pointer.
  - Outputs: grant one-hot and grant index.
- The top level holds the FSM, gap counter, pending storage, `s_id` and `ovf` registers.

## Test plan
All scenarios use `N_REQ`=4 and `GAP`=16.

1. Single pulse on `req_pluse[2]` at cycle 10 → `s_pluse` high only at cycle 12, `s_id`=2, `busy` high for cycles 12–26.
2. `req_pluse`=4'b1111 for one cycle → four pulses spaced exactly 16 cycles apart, `s_id` sequence 0,1,2,3, then `pend`=0.
3. Requester 1 pulses every 4 cycles for 40 cycles, with CNT_EN and `CNT_W`=4:
   - 10 requests → 10 issued pulses, all `s_id`=1, `ovf`=0.
   - Without CNT_EN: `ovf[1]`=1, and fewer than 10 pulses are issued.
4. Request and grant on the same edge for requester 3 while it is pending → its queue depth is unchanged, and the pulse count matches the request count.
5. Assert reset during GAP with 3 pulses queued → the cycle after reset, all outputs are 0, and no further `s_pluse` occurs.
6. Force `ovf[0]`, then pulse `ovf_clr` → `ovf[0]`=0 next cycle; `ovf_clr` coincident with a new overflow → `ovf[0]` stays 1.

Source files
------------

// File: rtl/pluse_sync_pkg.sv
// Shared types and helpers for the pluse_sync request scheduler.
// Enable PLUSE_SCHED_CNT_EN for multi-deep pending counters.
package pluse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } sched_state_t;

  localparam int GAP_MIN = 2;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pluse_rr_arb.sv
// Combinational round-robin arbiter; search starts after ptr.
// Lowest index above ptr wins, else lowest index overall.
module pluse_rr_arb
  import pluse_sync_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic            hi_hit;
  logic            lo_hit;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;

  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) > ptr)) begin
        hi_hit = 1'b1;
        hi_id  = ID_W'(i);
      end
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    gnt    = '0;
    gnt_id = hi_hit ? hi_id : lo_id;
    if (hi_hit || lo_hit)
      gnt = N_REQ'(1) << gnt_id;
  end

endmodule

// File: rtl/pluse_sync_sched.sv
// Round-robin pulse scheduler feeding one shared pluse_sync.
// PLUSE_SCHED_CNT_EN: CNT_W-bit pending counters instead of bits.
module pluse_sync_sched
  import pluse_sync_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP   = 16,
  parameter int CNT_W = 4,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic [N_REQ-1:0] req_pluse,
  input  logic             ovf_clr,
  output logic             s_pluse,
  output logic [ID_W-1:0]  s_id,
  output logic             busy,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] ovf
);

  localparam int GW = $clog2(GAP + 1);

  sched_state_t     state, state_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] pend_v;
  logic [N_REQ-1:0] full;
  logic [N_REQ-1:0] dec;
  logic [N_REQ-1:0] ovf_set;
  logic             do_gnt;

  pluse_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (pend_v),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign do_gnt  = (state == ST_IDLE) && (|pend_v);
  assign dec     = do_gnt ? gnt : '0;
  assign ovf_set = req_pluse & full & ~dec;

`ifdef PLUSE_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt [N_REQ];

  always_comb begin
    pend_v = '0;
    full   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pend_v[i] = |cnt[i];
      full[i]   = &cnt[i];
    end
  end

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= cnt[i]
                + CNT_W'(req_pluse[i] && !ovf_set[i])
                - CNT_W'(dec[i]);
    end
  end
`else
  logic [N_REQ-1:0] pbit;
  logic [CNT_W-1:0] unused_cnt_w;

  assign unused_cnt_w = '0;
  assign pend_v       = pbit;
  assign full         = pbit;

  // Request plus grant on one edge keeps the bit set.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n)
      pbit <= '0;
    else
      pbit <= req_pluse | (pbit & ~dec);
  end
`endif

  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    unique case (state)
      ST_IDLE: begin
        if (|pend_v)
          state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (GAP == GAP_MIN) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_GAP;
          gcnt_n  = GW'(GAP - 3);
        end
      end
      ST_GAP: begin
        if (gcnt == '0)
          state_n = ST_IDLE;
        else
          gcnt_n = gcnt - GW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      state <= ST_IDLE;
      gcnt  <= '0;
      ptr   <= ID_W'(N_REQ - 1);
      s_id  <= '0;
      ovf   <= '0;
    end else begin
      state <= state_n;
      gcnt  <= gcnt_n;
      ovf   <= (ovf & ~{N_REQ{ovf_clr}}) | ovf_set;
      if (do_gnt) begin
        ptr  <= gnt_id;
        s_id <= gnt_id;
      end
    end
  end

  assign s_pluse = (state == ST_ISSUE);
  assign busy    = (state != ST_IDLE);
  assign pend    = pend_v;

endmodule

// File: tb/tb_pluse_sync_sched.sv
// Bench for pluse_sync_sched: vector table, directed corners, random.
// Reference model tracks queue depths and issue times arithmetically.
module tb_pluse_sync_sched;

  localparam int N   = 4;
  localparam int GAP = 16;
`ifdef PLUSE_SCHED_CNT_EN
  localparam int MAXQ = 15;
`else
  localparam int MAXQ = 1;
`endif

  logic         src_clk;
  logic         src_rst_n;
  logic [N-1:0] req_pluse;
  logic         ovf_clr;
  logic         s_pluse;
  logic [1:0]   s_id;
  logic         busy;
  logic [N-1:0] pend;
  logic [N-1:0] ovf;

  pluse_sync_sched #(
    .N_REQ (N),
    .GAP   (GAP),
    .CNT_W (4)
  ) dut (
    .src_clk   (src_clk),
    .src_rst_n (src_rst_n),
    .req_pluse (req_pluse),
    .ovf_clr   (ovf_clr),
    .s_pluse   (s_pluse),
    .s_id      (s_id),
    .busy      (busy),
    .pend      (pend),
    .ovf       (ovf)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  int checks = 0;
  int errors = 0;

  // model state
  int       q [N];
  logic [N-1:0] movf;
  int       mptr;
  int       ms_id;
  int       lg;
  int       next_idle;
  int       cyc_n = 0;

  // last sampled outputs
  logic         a_sp;
  logic [1:0]   a_id;
  logic         a_busy;
  logic [N-1:0] a_pend;
  logic [N-1:0] a_ovf;
  int           pcyc [$];
  int           pid  [$];

  typedef struct {
    logic [N-1:0] req;
    int           rep;
    logic         sp;
    logic [1:0]   id;
    logic         bsy;
    logic [N-1:0] pnd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc_n);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) q[i] = 0;
    movf      = '0;
    mptr      = N - 1;
    ms_id     = 0;
    lg        = -100;
    next_idle = 0;
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic clr,
                     input logic rn);
    logic         e_sp;
    logic         e_busy;
    logic [N-1:0] e_pend;
    bit           found;
    req_pluse = r;
    ovf_clr   = clr;
    src_rst_n = rn;
    @(negedge src_clk);
    e_sp   = (cyc_n == lg + 1);
    e_busy = (cyc_n < next_idle);
    for (int i = 0; i < N; i++) e_pend[i] = (q[i] > 0);
    a_sp   = s_pluse;
    a_id   = s_id;
    a_busy = busy;
    a_pend = pend;
    a_ovf  = ovf;
    if (a_sp) begin
      pcyc.push_back(cyc_n);
      pid.push_back(int'(a_id));
    end
    chk("model", {a_sp, a_id, a_busy, a_pend, a_ovf},
        {e_sp, 2'(ms_id), e_busy, e_pend, movf});
    if (!rn) begin
      mreset();
    end else begin
      found = 0;
      if (!e_busy) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (mptr + k) % N;
          if (!found && q[j] > 0) begin
            found     = 1;
            q[j]--;
            mptr      = j;
            ms_id     = j;
            lg        = cyc_n;
            next_idle = cyc_n + GAP;
          end
        end
      end
      if (clr) movf = '0;
      for (int i = 0; i < N; i++)
        if (r[i]) begin
          if (q[i] < MAXQ) q[i]++;
          else movf[i] = 1'b1;
        end
    end
    cyc_n++;
    @(posedge src_clk);
    #1;
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b0);
    pcyc.delete();
    pid.delete();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b1);
  endtask

  initial begin
    int n1;
    bit seen;
    logic [N-1:0] r;
    req_pluse = '0;
    ovf_clr   = 1'b0;
    src_rst_n = 1'b0;
    mreset();
    repeat (2) @(posedge src_clk);
    #1;

    // reset state
    cyc('0, 1'b0, 1'b1);
    chk("rst_outs", {a_sp, a_id, a_busy, a_pend, a_ovf}, 0);

    // table: single pulse then two simultaneous requesters
    tbl[0] = '{4'b0100, 1,  1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[1] = '{4'b0000, 1,  1'b0, 2'd0, 1'b0, 4'b0100};
    tbl[2] = '{4'b0000, 1,  1'b1, 2'd2, 1'b1, 4'b0000};
    tbl[3] = '{4'b1001, 1,  1'b0, 2'd2, 1'b1, 4'b0000};
    tbl[4] = '{4'b0000, 13, 1'b0, 2'd2, 1'b1, 4'b1001};
    tbl[5] = '{4'b0000, 1,  1'b0, 2'd2, 1'b0, 4'b1001};
    tbl[6] = '{4'b0000, 1,  1'b1, 2'd3, 1'b1, 4'b0001};
    tbl[7] = '{4'b0000, 15, 1'b0, 2'd3, 1'b0, 4'b0001};
    tbl[8] = '{4'b0000, 1,  1'b1, 2'd0, 1'b1, 4'b0000};
    do_reset();
    for (int t = 0; t < 9; t++) begin
      for (int k = 0; k < tbl[t].rep; k++)
        cyc(tbl[t].req, 1'b0, 1'b1);
      chk($sformatf("tbl%0d", t), {a_sp, a_id, a_busy, a_pend},
          {tbl[t].sp, tbl[t].id, tbl[t].bsy, tbl[t].pnd});
    end

    // all four at once: ids 0..3 spaced by GAP
    do_reset();
    cyc(4'b1111, 1'b0, 1'b1);
    idle_n(80);
    chk("t2_npulse", pcyc.size(), 4);
    if (pcyc.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_id", pid[i], i);
      for (int i = 1; i < 4; i++)
        chk("t2_space", pcyc[i] - pcyc[i-1], GAP);
    end
    chk("t2_pend", a_pend, 0);

    // requester 1 every 4 cycles, ten requests
    do_reset();
    for (int k = 0; k < 40; k++)
      cyc((k % 4 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b1);
    idle_n(200);
    n1 = 0;
    foreach (pid[i]) if (pid[i] == 1) n1++;
    chk("t3_allid1", n1, pid.size());
`ifdef PLUSE_SCHED_CNT_EN
    chk("t3_count", n1, 10);
    chk("t3_ovf", a_ovf, 0);
`else
    chk("t3_fewer", int'(n1 < 10), 1);
    chk("t3_ovf1", a_ovf[1], 1);
`endif

    // request coinciding with grant for requester 3
    do_reset();
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b1);
    chk("t4_pend_pre", a_pend, 4'b1000);
    cyc('0, 1'b0, 1'b1);
    chk("t4_issue", {a_sp, a_id, a_pend, a_ovf}, {1'b1, 2'd3, 4'b1000, 4'b0000});
    idle_n(40);
    chk("t4_npulse", pcyc.size(), 2);

    // reset during GAP with pulses queued
    do_reset();
    cyc(4'b0111, 1'b0, 1'b1);
    idle_n(3);
    cyc(4'b0001, 1'b0, 1'b1);
    idle_n(2);
    chk("t5_busy", a_busy, 1);
    cyc('0, 1'b0, 1'b0);
    pcyc.delete();
    cyc('0, 1'b0, 1'b1);
    chk("t5_zero", {a_sp, a_id, a_busy, a_pend, a_ovf}, 0);
    idle_n(40);
    chk("t5_nopulse", pcyc.size(), 0);

    // overflow, clear coincident with new overflow, then clean clear
    do_reset();
    for (int k = 0; k < 20; k++) cyc(4'b0001, 1'b0, 1'b1);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b0001, 1'b0, 1'b1);
      seen = a_sp;
    end
    chk("t6_issue_seen", seen, 1);
    cyc(4'b0001, 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b1);
    chk("t6_set_wins", a_ovf[0], 1);
    cyc('0, 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b1);
    chk("t6_cleared", a_ovf[0], 0);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 7) == 0);
      cyc(r, $urandom_range(0, 31) == 0, $urandom_range(0, 599) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
